drift_controller: RTL
=====================

Name: drift_controller

Overview:
- Sequences phase-drift requests into `peemptive_event_generation`.
- Arbitrates NUM_SRC drift sources round-robin and nets them into one signed drift accumulator.
- Chooses the clock half (high/low) each drift lands in, using the unpausable clock state fed back from the generator.
- Issues at most one bounded drift step per clock period over the generator's req/ack handshake.

Parameters:
- NUM_SRC, 2, number of drift requesters (1..8).
- ACC_WIDTH, clks_alot_p::DRIFT_COUNTER_WIDTH+2, signed accumulator width.

Ports:
- sys_dom_i  in  common_p::clk_dom_s  one clock (sys_dom_i.clk); synchronous active-high reset (sys_dom_i.sync_rst).
- generation_en_i  in  1  permits issuing new drifts.
- flush_i  in  1  discard all accumulated drift.
- drift_half_sel_i  in  1  1: apply drifts during the high half; 0: during the low half.
- max_step_i  in  DRIFT_COUNTER_WIDTH  per-event magnitude cap; 0 means 2^DRIFT_COUNTER_WIDTH-1.
- src_valid_i  in  NUM_SRC  per-source request.
- src_ready_o  out  NUM_SRC  per-source accept (one-hot or zero).
- src_direction_i  in  NUM_SRC x drift_direction_e  per-source direction.
- src_amount_i  in  NUM_SRC x DRIFT_COUNTER_WIDTH  per-source magnitude.
- clk_state_i  in  clks_alot_p::clock_state_s  the generator's unpausable_clk_state_o; only .clk is used.
- drift_req_o  out  1  to the generator's drift_req_i.
- drift_ack_i  in  1  from the generator's drift_ack_o.
- drift_direction_o  out  drift_direction_e  to preemptive_drift_direction_i.
- drift_amount_o  out  DRIFT_COUNTER_WIDTH  to drift_amount_i.
- pending_o  out  1  accumulator non-zero.
- saturated_o  out  1  one-cycle pulse when an accepted request clipped the accumulator.

Behaviour:
- Reset values: acc=0, all outputs 0, state IDLE, round-robin pointer at source 0. Reset mid-handshake drops drift_req_o immediately; the generator must tolerate this.
- Sign convention: DRIFT_LENGTHEN = +amount; DRIFT_SHORTEN = -amount.
- Source acceptance:
  - Round-robin grant among asserted src_valid_i; src_ready_o = grant.
  - One acceptance per cycle; the pointer advances past the winner.
  - Sources are accepted in every state, but not while flush_i=1.
- Accumulator update (next cycle): acc_next = sat(acc + accepted_signed - acked_signed).
  - Both terms may apply in the same cycle.
  - Saturation is to ±(2^(ACC_WIDTH-1)-1) and pulses saturated_o.
- flush_i:
  - acc←0 next cycle.
  - An outstanding request is not retracted; its ack does not subtract.
  - The accumulator stays 0 until flush deasserts.
- FSM:
  - IDLE → ISSUE when generation_en_i & acc≠0 & clk_state_i.clk==drift_half_sel_i & !flush_i.
    - On this transition, register step=min(|acc|, cap) and direction=sign(acc).
    - drift_req_o=1 from the next cycle.
  - ISSUE: hold drift_req_o, drift_direction_o and drift_amount_o stable until drift_ack_i=1.
    - On ack: drop req the next cycle and subtract the signed step (unless flushed).
    - Go to WAIT_HALF.
    - generation_en_i falling during ISSUE does not abort the request.
  - WAIT_HALF → IDLE when clk_state_i.clk != drift_half_sel_i. This guarantees one drift per period.
- Latency: with acc≠0 and the half already matching, drift_req_o rises 1 cycle after entry to IDLE.
- drift_amount_o and drift_direction_o return to 0 after ack.
- Opposite-direction requests net: +5 then -5 yields acc=0 and no drift issued.
- pending_o = (acc≠0), registered.

Decomposition:
- clks_alot_p additions: drift_ctrl_state_e (IDLE, ISSUE, WAIT_HALF) and DRIFT_ACC_WIDTH.
- drift_direction_e is reused.
- One sub-module: drift_rr_arbiter (NUM_SRC round-robin, valid→grant, pointer register).

Test Plan (DRIFT_COUNTER_WIDTH=8, half_sel=1):
- Src0 LENGTHEN 10, cap 0, clk high, ack after 3 cycles → req rises 1 cycle after accept+acc update; amount=10, dir=LENGTHEN held 3 cycles; acc=0; no second req until clk goes low then high.
- Src0 SHORTEN 300 (two accepts of 150), cap 100 → three drifts of 100 SHORTEN, one per period, on consecutive high halves; pending_o falls after the third ack.
- Src0 and src1 valid continuously → grants alternate 0,1,0,1; simultaneous LENGTHEN 7 / SHORTEN 7 nets to acc=0, no req.
- New accept coinciding with ack: acc=20, step 20 acked while src1 adds LENGTHEN 5 → acc=5 next cycle.
- flush_i asserted during ISSUE → req held until ack; acc=0 after; no further drift.
- Repeated LENGTHEN 255 until clip → acc=511, saturated_o pulses once per clipped accept; reset asserted mid-ISSUE → drift_req_o=0 next cycle, acc=0.

Source files
------------

// File: rtl/drift_controller_pkg.sv
// Shared types for the drift controller: clock-domain bundle, generator clock state,
// drift direction, controller states and the width constants of the drift datapath.
package drift_controller_pkg;

  localparam int DRIFT_COUNTER_WIDTH = 8;
  localparam int DRIFT_ACC_WIDTH     = DRIFT_COUNTER_WIDTH + 2;

  typedef struct packed {
    logic clk;
    logic sync_rst;
  } clk_dom_s;

  typedef struct packed {
    logic clk;
  } clock_state_s;

  typedef enum logic {
    DRIFT_LENGTHEN = 1'b0,
    DRIFT_SHORTEN  = 1'b1
  } drift_direction_e;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_HALF = 2'd2
  } drift_ctrl_state_e;

  // A cap of zero stands for the largest representable step.
  function automatic logic [DRIFT_COUNTER_WIDTH-1:0] effective_cap(
    input logic [DRIFT_COUNTER_WIDTH-1:0] max_step
  );
    return (max_step == '0) ? '1 : max_step;
  endfunction

endpackage

// File: rtl/drift_rr_arbiter.sv
// Round-robin arbiter: grants the first valid requester at or after the pointer,
// then moves the pointer one past the winner.
module drift_rr_arbiter
  import drift_controller_pkg::*;
#(
  parameter int NUM_SRC = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [NUM_SRC-1:0] valid,
  output logic [NUM_SRC-1:0] grant
);

  localparam int PTR_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] win;
  logic             hit;

  function automatic logic [PTR_W-1:0] wrap(input logic [PTR_W-1:0] p, input int k);
    return PTR_W'((int'(p) + k) % NUM_SRC);
  endfunction

  always_comb begin
    grant = '0;
    win   = ptr;
    hit   = 1'b0;
    if (en) begin
      for (int k = 0; k < NUM_SRC; k++) begin
        if (!hit && valid[wrap(ptr, k)]) begin
          grant[wrap(ptr, k)] = 1'b1;
          win                 = wrap(ptr, k);
          hit                 = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (hit) begin
      ptr <= (win == PTR_W'(NUM_SRC - 1)) ? '0 : win + PTR_W'(1);
    end
  end

endmodule

// File: rtl/drift_controller.sv
// Nets round-robin drift requests into a saturating signed accumulator and issues at
// most one capped drift step per generator clock period over a req/ack handshake.
module drift_controller
  import drift_controller_pkg::*;
#(
  parameter int NUM_SRC   = 2,
  parameter int ACC_WIDTH = DRIFT_ACC_WIDTH
) (
  input  clk_dom_s                                          sys_dom_i,
  input  logic                                              generation_en_i,
  input  logic                                              flush_i,
  input  logic                                              drift_half_sel_i,
  input  logic [DRIFT_COUNTER_WIDTH-1:0]                    max_step_i,
  input  logic [NUM_SRC-1:0]                                src_valid_i,
  output logic [NUM_SRC-1:0]                                src_ready_o,
  input  drift_direction_e [NUM_SRC-1:0]                    src_direction_i,
  input  logic [NUM_SRC-1:0][DRIFT_COUNTER_WIDTH-1:0]       src_amount_i,
  input  clock_state_s                                      clk_state_i,
  output logic                                              drift_req_o,
  input  logic                                              drift_ack_i,
  output drift_direction_e                                  drift_direction_o,
  output logic [DRIFT_COUNTER_WIDTH-1:0]                    drift_amount_o,
  output logic                                              pending_o,
  output logic                                              saturated_o
);

  localparam int DW    = DRIFT_COUNTER_WIDTH;
  localparam int SUM_W = ACC_WIDTH + 2;
  localparam logic signed [SUM_W-1:0] ACC_MAX = SUM_W'((2 ** (ACC_WIDTH - 1)) - 1);

  logic                        rst;
  drift_ctrl_state_e           state, state_next;
  logic signed [ACC_WIDTH-1:0] acc, acc_next;
  logic [NUM_SRC-1:0]          grant;
  logic                        grant_any, ack_take, clipped, load, release_req;
  logic signed [SUM_W-1:0]     accepted, acked, sum;
  logic [ACC_WIDTH-1:0]        acc_mag, cap_ext;
  logic [DW-1:0]               cap, step_new;

  function automatic logic signed [SUM_W-1:0] signed_term(
    input logic [DW-1:0] mag, input drift_direction_e dir
  );
    logic signed [SUM_W-1:0] m;
    m = $signed(SUM_W'(mag));
    return (dir == DRIFT_SHORTEN) ? -m : m;
  endfunction

  function automatic logic signed [ACC_WIDTH-1:0] sat_acc(input logic signed [SUM_W-1:0] v);
    if (v > ACC_MAX)  return ACC_WIDTH'(ACC_MAX);
    if (v < -ACC_MAX) return ACC_WIDTH'(-ACC_MAX);
    return ACC_WIDTH'(v);
  endfunction

  assign rst         = sys_dom_i.sync_rst;
  assign src_ready_o = grant;

  drift_rr_arbiter #(.NUM_SRC(NUM_SRC)) u_arb (
    .clk   (sys_dom_i.clk),
    .rst   (rst),
    .en    (!flush_i),
    .valid (src_valid_i),
    .grant (grant)
  );

  // Accumulator: accepted request in, acknowledged step out, both in one cycle.
  always_comb begin
    accepted = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (grant[k]) accepted = signed_term(src_amount_i[k], src_direction_i[k]);
    end
    grant_any = |grant;
    ack_take  = (state == ISSUE) && drift_ack_i && !flush_i;
    acked     = ack_take ? signed_term(drift_amount_o, drift_direction_o) : '0;
    sum       = SUM_W'(acc) + accepted - acked;
    clipped   = (sum > ACC_MAX) || (sum < -ACC_MAX);
    acc_next  = flush_i ? '0 : sat_acc(sum);
  end

  always_comb begin
    cap      = effective_cap(max_step_i);
    acc_mag  = acc[ACC_WIDTH-1] ? ACC_WIDTH'(-acc) : ACC_WIDTH'(acc);
    cap_ext  = ACC_WIDTH'(cap);
    step_new = (acc_mag < cap_ext) ? acc_mag[DW-1:0] : cap;
  end

  always_comb begin
    state_next  = state;
    load        = 1'b0;
    release_req = 1'b0;
    case (state)
      IDLE: begin
        if (generation_en_i && (acc != '0) && (clk_state_i.clk == drift_half_sel_i) && !flush_i) begin
          state_next = ISSUE;
          load       = 1'b1;
        end
      end
      ISSUE: begin
        if (drift_ack_i) begin
          state_next  = WAIT_HALF;
          release_req = 1'b1;
        end
      end
      WAIT_HALF: begin
        // Leaving the drift half first is what limits us to one drift per period.
        if (clk_state_i.clk != drift_half_sel_i) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge sys_dom_i.clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge sys_dom_i.clk) begin
    if (rst) begin
      acc               <= '0;
      pending_o         <= 1'b0;
      saturated_o       <= 1'b0;
      drift_req_o       <= 1'b0;
      drift_amount_o    <= '0;
      drift_direction_o <= DRIFT_LENGTHEN;
    end else begin
      acc         <= acc_next;
      pending_o   <= (acc_next != '0);
      saturated_o <= grant_any && clipped;
      drift_req_o <= (state_next == ISSUE);
      if (load) begin
        drift_amount_o    <= step_new;
        drift_direction_o <= acc[ACC_WIDTH-1] ? DRIFT_SHORTEN : DRIFT_LENGTHEN;
      end else if (release_req) begin
        drift_amount_o    <= '0;
        drift_direction_o <= DRIFT_LENGTHEN;
      end
    end
  end

endmodule
